// File: rtl/som_sweep_if.sv
// Handshake, drive and result bundle between the SOM sweep sequencer and its host.
// Golden-check signals exist only when SOM_GOLDEN_CHECK_EN is defined.
interface som_sweep_if;
  logic        start;
  logic        abort;
  logic        sweep_both;
  logic        f_in;
  logic [3:0]  dut_abcd;
  logic        dut_en;
  logic        busy;
  logic        done;
  logic [15:0] tt_map0;
  logic [15:0] tt_map1;
  logic [5:0]  ones_cnt;
`ifdef SOM_GOLDEN_CHECK_EN
  logic [15:0] exp_map;
  logic        mismatch;
  logic [3:0]  err_idx;

  modport master (
    input  start, abort, sweep_both, f_in, exp_map,
    output dut_abcd, dut_en, busy, done, tt_map0, tt_map1, ones_cnt, mismatch, err_idx
  );
  modport slave (
    output start, abort, sweep_both, f_in, exp_map,
    input  dut_abcd, dut_en, busy, done, tt_map0, tt_map1, ones_cnt, mismatch, err_idx
  );
`else
  modport master (
    input  start, abort, sweep_both, f_in,
    output dut_abcd, dut_en, busy, done, tt_map0, tt_map1, ones_cnt
  );
  modport slave (
    output start, abort, sweep_both, f_in,
    input  dut_abcd, dut_en, busy, done, tt_map0, tt_map1, ones_cnt
  );
`endif
endinterface

// File: rtl/som_sweep_ctrl.sv
// Sweeps the enable-gated SOM function unit over all ABCD points and records truth-table maps.
// Optional golden comparison against exp_map is enabled by defining SOM_GOLDEN_CHECK_EN.
module som_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic         clk,
  input logic         rst_n,
  som_sweep_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYC);

  state_t      r_state;
  state_t      w_fsm_next;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_abcd;
  logic        r_en;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_map0;
  logic [15:0] r_map1;
  logic [5:0]  r_ones;
  logic [15:0] w_bit;
  logic [15:0] w_map0_smp;
  logic [15:0] w_map1_smp;
  logic        w_abort;

`ifdef SOM_GOLDEN_CHECK_EN
  logic        r_sweep_both;
  logic        r_mismatch;
  logic [3:0]  r_err_idx;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        res = 4'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the sampled map/bit values
  always_comb begin
    w_fsm_next = r_state;
    w_bit      = 16'd1 << r_idx;
    w_map0_smp = r_map0;
    w_map1_smp = r_map1;
    w_abort    = bus.abort && (r_state != ST_IDLE);
    if (bus.f_in && r_en) begin
      w_map1_smp = r_map1 | w_bit;
    end else if (bus.f_in) begin
      w_map0_smp = r_map0 | w_bit;
    end else begin
      w_map1_smp = r_map1;
    end
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_fsm_next = ST_DRIVE;
        end else begin
          w_fsm_next = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (LP_SETTLE != 4'd0) begin
          w_fsm_next = ST_SETTLE;
        end else begin
          w_fsm_next = ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt <= 4'd1) begin
          w_fsm_next = ST_SAMPLE;
        end else begin
          w_fsm_next = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if ((r_idx == 4'd15) && r_en) begin
          w_fsm_next = ST_DONE;
        end else begin
          w_fsm_next = ST_DRIVE;
        end
      end
      ST_DONE:  w_fsm_next = ST_IDLE;
      default:  w_fsm_next = ST_IDLE;
    endcase
    w_next = w_abort ? ST_IDLE : w_fsm_next;
  end

  // Sweep datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 4'd0;
      r_cnt  <= 4'd0;
      r_abcd <= 4'd0;
      r_en   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_map0 <= 16'd0;
      r_map1 <= 16'd0;
      r_ones <= 6'd0;
`ifdef SOM_GOLDEN_CHECK_EN
      r_sweep_both <= 1'b0;
      r_mismatch   <= 1'b0;
      r_err_idx    <= 4'd0;
`endif
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
      if (w_abort) begin
        r_abcd <= 4'd0;
        r_en   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_abcd <= 4'd0;
            if (bus.start) begin
              r_map0 <= 16'd0;
              r_map1 <= 16'd0;
              r_ones <= 6'd0;
              r_idx  <= 4'd0;
              r_en   <= ~bus.sweep_both;
`ifdef SOM_GOLDEN_CHECK_EN
              r_sweep_both <= bus.sweep_both;
              r_mismatch   <= 1'b0;
              r_err_idx    <= 4'd0;
`endif
            end else begin
              r_en <= 1'b0;
            end
          end
          ST_DRIVE: begin
            r_abcd <= r_idx;
            r_cnt  <= LP_SETTLE;
          end
          ST_SETTLE: begin
            r_cnt <= r_cnt - 4'd1;
          end
          ST_SAMPLE: begin
            r_map0 <= w_map0_smp;
            r_map1 <= w_map1_smp;
            r_ones <= r_ones + {5'd0, bus.f_in};
            if (r_idx != 4'd15) begin
              r_idx <= r_idx + 4'd1;
            end else if (!r_en) begin
              // Second half of a dual sweep revisits every index with E=1
              r_en  <= 1'b1;
              r_idx <= 4'd0;
            end else begin
`ifdef SOM_GOLDEN_CHECK_EN
              r_mismatch <= (w_map1_smp != bus.exp_map) ||
                            (r_sweep_both && (w_map0_smp != 16'd0));
              r_err_idx  <= lowest_set(w_map1_smp ^ bus.exp_map);
`endif
              r_idx <= r_idx;
            end
          end
          ST_DONE: begin
            r_abcd <= 4'd0;
            r_en   <= 1'b0;
          end
          default: begin
            r_abcd <= 4'd0;
            r_en   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dut_abcd = r_abcd;
  assign bus.dut_en   = r_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.tt_map0  = r_map0;
  assign bus.tt_map1  = r_map1;
  assign bus.ones_cnt = r_ones;
`ifdef SOM_GOLDEN_CHECK_EN
  assign bus.mismatch = r_mismatch;
  assign bus.err_idx  = r_err_idx;
`endif

endmodule
